// File: rtl/fp_cvt_sched.sv
// fp_cvt_sched: two-requester round-robin scheduler and 3-stage sequencer
// (issue -> capture -> response) for the shared conversion datapath and rounder.
module fp_cvt_sched #(
  parameter int TAG_W = 4,
  parameter int RND_W = 84
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][1:0]        req_kind,
  input  logic [1:0][64:0]       req_data,
  input  logic [1:0][1:0]        req_op,
  input  logic [1:0][1:0]        req_fmt,
  input  logic [1:0][2:0]        req_rm,
  input  logic [1:0][9:0]        req_class,
  input  logic [1:0][TAG_W-1:0]  req_tag,
  output logic [1:0]             cvt_kind,
  output logic [64:0]            cvt_data,
  output logic [1:0]             cvt_op,
  output logic [1:0]             cvt_fmt,
  output logic [2:0]             cvt_rm,
  output logic [9:0]             cvt_class,
  input  logic [63:0]            cvt_f2i_result,
  input  logic [4:0]             cvt_f2i_flags,
  input  logic [RND_W-1:0]       cvt_rnd,
  output logic [RND_W-1:0]       rnd_in,
  input  logic [63:0]            rnd_result,
  input  logic [4:0]             rnd_flags,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_id,
  output logic [TAG_W-1:0]       resp_tag,
  output logic [63:0]            resp_result,
  output logic [4:0]             resp_flags,
  output logic                   busy
);

  localparam logic [1:0] KIND_F2I  = 2'd1;
  localparam logic [1:0] KIND_RSVD = 2'd3;

  logic             w_adv;
  logic [1:0]       w_elig;
  logic [1:0]       w_grant;
  logic             w_hs;
  logic             w_win;
  logic             r_rr;

  logic             r_s1_v;
  logic             r_s1_id;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_v;
  logic [1:0]       r_s2_kind;
  logic             r_s2_id;
  logic [TAG_W-1:0] r_s2_tag;
  logic [63:0]      r_s2_res;
  logic [4:0]       r_s2_flags;
  logic [RND_W-1:0] r_s2_rnd;

  // The whole pipe moves together; a stalled response freezes every stage.
  assign w_adv = ~resp_valid | resp_ready;

  // Reserved kind is never eligible, so its requester simply never sees ready.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_elig
      assign w_elig[gi] = req_valid[gi] & (req_kind[gi] != KIND_RSVD);
    end
  endgenerate

  // Round-robin pick: pointer breaks the tie only when both are eligible.
  always_comb begin
    w_grant = 2'b00;
    if (&w_elig) begin
      w_grant[r_rr] = 1'b1;
    end else begin
      w_grant = w_elig;
    end
  end

  assign req_ready = w_grant & {2{w_adv & ~flush & ~reset}};
  assign w_hs      = |req_ready;
  assign w_win     = req_ready[1];
  assign busy      = r_s1_v | r_s2_v | resp_valid;

  // Pointer moves to the other requester after each real handshake only.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr <= 1'b0;
    end else if (w_hs) begin
      r_rr <= ~w_win;
    end
  end

  // Issue stage: registers the winner; its fields drive the converter directly.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_v    <= 1'b0;
      r_s1_id   <= 1'b0;
      r_s1_tag  <= '0;
      cvt_kind  <= '0;
      cvt_data  <= '0;
      cvt_op    <= '0;
      cvt_fmt   <= '0;
      cvt_rm    <= '0;
      cvt_class <= '0;
    end else if (flush) begin
      r_s1_v <= 1'b0;
    end else if (w_adv) begin
      r_s1_v <= w_hs;
      if (w_hs) begin
        r_s1_id   <= w_win;
        r_s1_tag  <= req_tag[w_win];
        cvt_kind  <= req_kind[w_win];
        cvt_data  <= req_data[w_win];
        cvt_op    <= req_op[w_win];
        cvt_fmt   <= req_fmt[w_win];
        cvt_rm    <= req_rm[w_win];
        cvt_class <= req_class[w_win];
      end
    end
  end

  // Capture stage: keeps either the finished f2i result or the rounding bundle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s2_v     <= 1'b0;
      r_s2_kind  <= '0;
      r_s2_id    <= 1'b0;
      r_s2_tag   <= '0;
      r_s2_res   <= '0;
      r_s2_flags <= '0;
      r_s2_rnd   <= '0;
    end else if (flush) begin
      r_s2_v <= 1'b0;
    end else if (w_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_kind <= cvt_kind;
        r_s2_id   <= r_s1_id;
        r_s2_tag  <= r_s1_tag;
        if (cvt_kind == KIND_F2I) begin
          r_s2_res   <= cvt_f2i_result;
          r_s2_flags <= cvt_f2i_flags;
        end else begin
          r_s2_rnd <= cvt_rnd;
        end
      end
    end
  end

  // Rounder sees a live bundle only for a valid f2f/i2f in capture; else zeros.
  assign rnd_in = (r_s2_v && (r_s2_kind != KIND_F2I)) ? r_s2_rnd : '0;

  // Response register: picks rounder output or the bypassed f2i result.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_tag    <= '0;
      resp_result <= '0;
      resp_flags  <= '0;
    end else if (flush) begin
      resp_valid <= 1'b0;
    end else if (w_adv) begin
      resp_valid <= r_s2_v;
      if (r_s2_v) begin
        resp_id  <= r_s2_id;
        resp_tag <= r_s2_tag;
        if (r_s2_kind == KIND_F2I) begin
          resp_result <= r_s2_res;
          resp_flags  <= r_s2_flags;
        end else begin
          resp_result <= rnd_result;
          resp_flags  <= rnd_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_cvt_sched.sv
// tb_fp_cvt_sched: directed checks of arbitration, latency, stall, mixed kinds,
// flush and reset. Converter and rounder are simple stubs driven from DUT outputs.
module tb_fp_cvt_sched;

  logic             clock;
  logic             reset;
  logic             flush;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][1:0]  req_kind;
  logic [1:0][64:0] req_data;
  logic [1:0][1:0]  req_op;
  logic [1:0][1:0]  req_fmt;
  logic [1:0][2:0]  req_rm;
  logic [1:0][9:0]  req_class;
  logic [1:0][3:0]  req_tag;
  logic [1:0]       cvt_kind;
  logic [64:0]      cvt_data;
  logic [1:0]       cvt_op;
  logic [1:0]       cvt_fmt;
  logic [2:0]       cvt_rm;
  logic [9:0]       cvt_class;
  logic [63:0]      cvt_f2i_result;
  logic [4:0]       cvt_f2i_flags;
  logic [83:0]      cvt_rnd;
  logic [83:0]      rnd_in;
  logic [63:0]      rnd_result;
  logic [4:0]       rnd_flags;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [3:0]       resp_tag;
  logic [63:0]      resp_result;
  logic [4:0]       resp_flags;
  logic             busy;

  int checks;
  int errors;

  fp_cvt_sched #(.TAG_W(4), .RND_W(84)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_data(req_data), .req_op(req_op), .req_fmt(req_fmt), .req_rm(req_rm),
    .req_class(req_class), .req_tag(req_tag),
    .cvt_kind(cvt_kind), .cvt_data(cvt_data), .cvt_op(cvt_op), .cvt_fmt(cvt_fmt),
    .cvt_rm(cvt_rm), .cvt_class(cvt_class),
    .cvt_f2i_result(cvt_f2i_result), .cvt_f2i_flags(cvt_f2i_flags), .cvt_rnd(cvt_rnd),
    .rnd_in(rnd_in), .rnd_result(rnd_result), .rnd_flags(rnd_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_tag(resp_tag), .resp_result(resp_result), .resp_flags(resp_flags),
    .busy(busy)
  );

  // Converter stub: f2i passes the operand through, flags = class[4:0].
  // Bundle layout: {data, class, rm, fmt, op, kind}.
  assign cvt_f2i_result = cvt_data[63:0];
  assign cvt_f2i_flags  = cvt_class[4:0];
  assign cvt_rnd        = {cvt_data, cvt_class, cvt_rm, cvt_fmt, cvt_op, cvt_kind};
  // Rounder stub: result = operand + 0x100, flags = class[4:0] ^ 0x10.
  assign rnd_result     = rnd_in[82:19] + 64'h100;
  assign rnd_flags      = rnd_in[13:9] ^ 5'h10;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] k,
                         input logic [64:0] d, input logic [9:0] c, input logic [3:0] t);
    req_valid[i] = v;
    req_kind[i]  = k;
    req_data[i]  = d;
    req_class[i] = c;
    req_tag[i]   = t;
  endtask

  logic [1:0]  m_kind [3];
  logic [64:0] m_data [3];
  logic [9:0]  m_cls  [3];
  logic [83:0] exp_rnd;
  logic [3:0]  exp_tag;

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; flush = 1'b0; resp_ready = 1'b1;
    req_valid = '0; req_kind = '0; req_data = '0; req_op = '0;
    req_fmt = '0; req_rm = '0; req_class = '0; req_tag = '0;

    // ---- reset state ----
    tick(); tick();
    reset = 1'b0; #1;
    chk("rst_resp_valid", 128'(resp_valid), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_req_ready", 128'(req_ready), 128'h0);
    chk("rst_rnd_in", 128'(rnd_in), 128'h0);
    chk("rst_cvt_data", 128'(cvt_data), 128'h0);
    chk("rst_resp_result", 128'(resp_result), 128'h0);

    // ---- single f2i, latency 3 ----
    set_req(0, 1'b1, 2'd1, 65'h2A, 10'd0, 4'd3); #1;
    chk("t1_ready", 128'(req_ready), 128'h1);
    tick();
    set_req(0, 1'b0, 2'd0, 65'h0, 10'd0, 4'd0); #1;
    chk("t1_cvt_kind", 128'(cvt_kind), 128'h1);
    chk("t1_cvt_data", 128'(cvt_data), 128'h2A);
    chk("t1_early_valid", 128'(resp_valid), 128'h0);
    tick(); tick();
    chk("t1_resp_valid", 128'(resp_valid), 128'h1);
    chk("t1_resp_id", 128'(resp_id), 128'h0);
    chk("t1_resp_tag", 128'(resp_tag), 128'h3);
    chk("t1_resp_result", 128'(resp_result), 128'h2A);
    chk("t1_resp_flags", 128'(resp_flags), 128'h0);
    tick();
    chk("t1_drain_valid", 128'(resp_valid), 128'h0);
    chk("t1_drain_busy", 128'(busy), 128'h0);

    // reset pulse puts rr back to 0 and clears held response fields
    reset = 1'b1; tick(); reset = 1'b0; #1;
    chk("rst2_resp_tag", 128'(resp_tag), 128'h0);
    chk("rst2_resp_result", 128'(resp_result), 128'h0);

    // ---- both requesters f2f, round-robin 0,1,0,1 ----
    for (int k = 0; k < 7; k++) begin
      set_req(0, k < 4, 2'd0, 65'h1, 10'd0, 4'd1);
      set_req(1, k < 4, 2'd0, 65'h2, 10'd0, 4'd2);
      #1;
      if (k < 4) chk($sformatf("rr_ready_%0d", k), 128'(req_ready), (k % 2 == 0) ? 128'h1 : 128'h2);
      if (k >= 3) begin
        exp_tag = ((k - 3) % 2 == 0) ? 4'd1 : 4'd2;
        chk($sformatf("rr_valid_%0d", k), 128'(resp_valid), 128'h1);
        chk($sformatf("rr_tag_%0d", k), 128'(resp_tag), 128'(exp_tag));
        chk($sformatf("rr_result_%0d", k), 128'(resp_result), 128'h100 + 128'(exp_tag));
        chk($sformatf("rr_flags_%0d", k), 128'(resp_flags), 128'h10);
      end
      tick();
    end
    chk("rr_drain_valid", 128'(resp_valid), 128'h0);

    // ---- three i2f from req1 with a 4-cycle response stall ----
    for (int k = 0; k < 12; k++) begin
      set_req(1, k < 3, 2'd2, 65'h10 + 65'(k), 10'd3, 4'(8 + k));
      set_req(0, (k >= 3) && (k <= 7), 2'd1, 65'h77, 10'd5, 4'd11);
      resp_ready = !((k >= 3) && (k <= 6));
      #1;
      if (k < 3)       chk($sformatf("st_ready_%0d", k), 128'(req_ready), 128'h2);
      else if (k == 7) chk($sformatf("st_ready_%0d", k), 128'(req_ready), 128'h1);
      else             chk($sformatf("st_ready_%0d", k), 128'(req_ready), 128'h0);
      chk($sformatf("st_valid_%0d", k), 128'(resp_valid), ((k >= 3) && (k <= 10)) ? 128'h1 : 128'h0);
      if ((k >= 3) && (k <= 10)) begin
        exp_tag = (k <= 7) ? 4'd8 : 4'(k + 1);
        chk($sformatf("st_tag_%0d", k), 128'(resp_tag), 128'(exp_tag));
        if (exp_tag == 4'd11) begin
          chk($sformatf("st_result_%0d", k), 128'(resp_result), 128'h77);
          chk($sformatf("st_flags_%0d", k), 128'(resp_flags), 128'h5);
        end else begin
          chk($sformatf("st_result_%0d", k), 128'(resp_result), 128'h110 + 128'(exp_tag - 4'd8));
          chk($sformatf("st_flags_%0d", k), 128'(resp_flags), 128'h13);
        end
      end
      tick();
    end
    resp_ready = 1'b1;

    // ---- mixed kinds f2i / i2f / f2i ----
    m_kind[0] = 2'd1; m_data[0] = 65'h55; m_cls[0] = 10'd1;
    m_kind[1] = 2'd2; m_data[1] = 65'h66; m_cls[1] = 10'd2;
    m_kind[2] = 2'd1; m_data[2] = 65'h77; m_cls[2] = 10'd4;
    exp_rnd = {65'h66, 10'd2, 7'd0, 2'd2};
    for (int k = 0; k < 7; k++) begin
      if (k < 3) set_req(0, 1'b1, m_kind[k], m_data[k], m_cls[k], 4'(5 + k));
      else       set_req(0, 1'b0, 2'd0, 65'h0, 10'd0, 4'd0);
      set_req(1, 1'b0, 2'd0, 65'h0, 10'd0, 4'd0);
      #1;
      if (k < 3) chk($sformatf("mx_ready_%0d", k), 128'(req_ready), 128'h1);
      if ((k == 2) || (k == 4)) chk($sformatf("mx_rnd_zero_%0d", k), 128'(rnd_in), 128'h0);
      if (k == 3) chk("mx_rnd_live", 128'(rnd_in), 128'(exp_rnd));
      if (k == 3) begin
        chk("mx_tag5", 128'(resp_tag), 128'h5);
        chk("mx_res5", 128'(resp_result), 128'h55);
        chk("mx_flg5", 128'(resp_flags), 128'h1);
      end
      if (k == 4) begin
        chk("mx_tag6", 128'(resp_tag), 128'h6);
        chk("mx_res6", 128'(resp_result), 128'h166);
        chk("mx_flg6", 128'(resp_flags), 128'h12);
      end
      if (k == 5) begin
        chk("mx_tag7", 128'(resp_tag), 128'h7);
        chk("mx_res7", 128'(resp_result), 128'h77);
        chk("mx_flg7", 128'(resp_flags), 128'h4);
      end
      if (k == 6) chk("mx_drain_valid", 128'(resp_valid), 128'h0);
      tick();
    end

    // ---- flush with all stages full ----
    for (int k = 0; k < 3; k++) begin
      set_req(1, 1'b1, 2'd1, 65'h12 + 65'(k), 10'd0, 4'(12 + k));
      #1;
      chk($sformatf("fl_fill_ready_%0d", k), 128'(req_ready), 128'h2);
      tick();
    end
    set_req(0, 1'b1, 2'd1, 65'h44, 10'd0, 4'd0);
    flush = 1'b1; #1;
    chk("fl_busy_before", 128'(busy), 128'h1);
    chk("fl_valid_before", 128'(resp_valid), 128'h1);
    chk("fl_ready_in_flush", 128'(req_ready), 128'h0);
    tick();
    flush = 1'b0; #1;
    chk("fl_valid_after", 128'(resp_valid), 128'h0);
    chk("fl_busy_after", 128'(busy), 128'h0);
    chk("fl_rr_unchanged", 128'(req_ready), 128'h1);
    tick();

    // ---- reserved kind on req0 alongside f2i on req1, then reset ----
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 2'd3, 65'h0, 10'd0, 4'd9);
      set_req(1, 1'b1, 2'd1, 65'h99, 10'd6, 4'd15);
      #1;
      chk($sformatf("rs_ready_%0d", k), 128'(req_ready), 128'h2);
      if (k == 2) begin
        chk("rs_tag0", 128'(resp_tag), 128'h0);
        chk("rs_res0", 128'(resp_result), 128'h44);
        chk("rs_id0", 128'(resp_id), 128'h0);
      end
      if (k == 3) begin
        chk("rs_tag15", 128'(resp_tag), 128'hF);
        chk("rs_res15", 128'(resp_result), 128'h99);
        chk("rs_flg15", 128'(resp_flags), 128'h6);
        chk("rs_id15", 128'(resp_id), 128'h1);
      end
      if (k < 3) tick();
    end
    reset = 1'b1; #1;
    chk("rs_ready_in_reset", 128'(req_ready), 128'h0);
    tick();
    reset = 1'b0;
    set_req(0, 1'b0, 2'd0, 65'h0, 10'd0, 4'd0);
    set_req(1, 1'b0, 2'd0, 65'h0, 10'd0, 4'd0);
    #1;
    chk("rs_valid_after", 128'(resp_valid), 128'h0);
    chk("rs_busy_after", 128'(busy), 128'h0);
    chk("rs_tag_after", 128'(resp_tag), 128'h0);
    chk("rs_result_after", 128'(resp_result), 128'h0);
    chk("rs_cvt_data_after", 128'(cvt_data), 128'h0);
    chk("rs_rnd_in_after", 128'(rnd_in), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_cvt_sched.md
Name: fp_cvt_sched

Overview:
- Two-requester scheduler and pipeline sequencer for the shared conversion datapath (f2f, f2i, i2f) and the shared rounding stage.
- Arbitrates conversion requests round-robin and registers the winner into an issue stage that drives the combinational converter.
- Captures the converter output and, for f2f/i2f, routes the captured rounding bundle through the shared rounder.
- Returns a registered, tagged response under valid/ready backpressure.

Parameters:
- TAG_W, 4, width of the requester-supplied transaction tag.
- RND_W, 84, width of the opaque packed rounding bundle (sig, expo, mant, rema, fmt, rm, grs, snan, qnan, dbz, inf, zero).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of all in-flight work
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept
- req_kind  in  2x2  0=f2f, 1=f2i, 2=i2f, 3=reserved
- req_data  in  2x65  operand (recoded float or integer)
- req_op  in  2x2  fcvt_op
- req_fmt  in  2x2  destination format
- req_rm  in  2x3  rounding mode
- req_class  in  2x10  operand classification
- req_tag  in  2xTAG_W  transaction tag
- cvt_kind, cvt_data, cvt_op, cvt_fmt, cvt_rm, cvt_class  out  2/65/2/2/3/10  S1 contents driven to the converter
- cvt_f2i_result  in  64  converter f2i result
- cvt_f2i_flags  in  5  converter f2i flags
- cvt_rnd  in  RND_W  converter rounding bundle (f2f or i2f, selected by kind)
- rnd_in  out  RND_W  S2 bundle driven to the rounder
- rnd_result  in  64  rounder result (combinational from rnd_in)
- rnd_flags  in  5  rounder flags
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accept
- resp_id  out  1  originating requester
- resp_tag  out  TAG_W  tag
- resp_result  out  64  result
- resp_flags  out  5  fflags
- busy  out  1  any stage valid

Behaviour:
- Pipeline
  - A (arbitrate, combinational) -> S1 (issue register) -> S2 (capture register) -> OUT (response register).
  - Accept at edge T gives resp_valid at T+3 with no stall.
  - One transaction enters per cycle at most; throughput is 1/cycle.
- Global advance: adv = !resp_valid | resp_ready. All stages load only when adv=1; otherwise every register holds.
- Arbitration
  - Eligible requesters: those with req_valid=1 and req_kind!=3.
  - If only one is eligible, grant it.
  - If both are eligible, grant the requester selected by pointer rr.
  - req_ready[i] = adv & grant[i] & !flush. At most one bit is high.
  - After a grant to requester i, rr <= ~i.
  - rr holds on cycles with no grant.
- Reserved kind: req_kind=3 is never granted and req_ready stays 0 for that requester. The requester must withdraw the request.
- S1 load: on handshake, capture kind, data, op, fmt, rm, class, tag and id, and set s1_v=1. Without a handshake, s1_v<=0 when adv=1.
- S2 load
  - S2 takes the S1 contents plus one payload selected by kind:
  - f2i: captures cvt_f2i_result and cvt_f2i_flags.
  - f2f and i2f: capture cvt_rnd.
  - rnd_in is driven from S2's captured bundle, and is all-zero when S2 is not f2f/i2f.
- OUT load
  - resp_result/resp_flags take rnd_result/rnd_flags for f2f/i2f.
  - They take the captured f2i result/flags for f2i.
  - resp_id and resp_tag come from S2.
- Order: responses leave strictly in acceptance order.
- Reset
  - s1_v, s2_v, resp_valid, busy and req_ready are 0.
  - rr is 0.
  - resp_result, resp_flags, resp_tag, resp_id and rnd_in are all 0.
  - cvt_* outputs are 0.
  - Reset overrides flush and the handshake.
- Flush
  - At the edge, clears s1_v, s2_v and resp_valid regardless of adv.
  - No handshake occurs in a flush cycle; req_ready is forced to 0.
  - rr is unchanged.
- Holding outputs: data outputs of invalid stages hold their last values, except rnd_in, which is zeroed as above.
- busy = s1_v | s2_v | resp_valid.
- Stall with new requests: requests presented during a stall see req_ready=0 and must hold stable. Sampling resumes in the first cycle with adv=1.

Test Plan:
- Reset, then req0 f2i, tag=3, with cvt_f2i_result=0x2A and flags=0. Required: req_ready0=1 at T; at T+3 resp_valid=1, id=0, tag=3, result=0x2A, flags=0.
- Both requesters valid with f2f, tags 1 and 2, rr=0, rnd stub returning result=tag+0x100. Required: grant order 0,1,0,1; responses tag 1,2,1,2 with results 0x101 and 0x102 on consecutive cycles.
- Three back-to-back i2f requests with resp_ready=0 from T+3 for 4 cycles. Required: resp holds the first response unchanged, req_ready=0, no loss; after resp_ready=1, tags emerge in order, one per cycle.
- Mixed kinds f2i, i2f, f2i (tags 5,6,7). Required: tag 6 carries rnd_result/rnd_flags; tags 5 and 7 carry the converter f2i values; rnd_in is 0 while S2 holds an f2i.
- flush asserted with all three stages valid. Required: next cycle resp_valid=0, busy=0, req_ready=0 during the flush cycle, rr unchanged.
- req0 kind=3 alongside req1 f2i. Required: only req1 is granted, repeatedly; req_ready0 stays 0; reset mid-stream clears everything in one cycle.
